// File: rtl/spi_sram_target.sv
// spi_sram_target: serial SRAM responder in the style of a 23LC512.
// It boots in single-bit SPI mode, enters quad mode on EQIO (0x38), and then
// serves sequential quad WRITE (0x02) and READ (0x03) against an internal byte
// array. The SPI pins are oversampled with the system clock.
module spi_sram_target #(
  parameter int MEM_ADDR_WIDTH  = 10,
  parameter int SRAM_ADDR_WIDTH = 16,
  parameter int DUMMY_BYTES     = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cs_pin,
  input  logic                      sck_pin,
  inout  wire  [3:0]                sio_pin,
  output logic                      quad_mode,
  output logic                      busy,
  input  logic [MEM_ADDR_WIDTH-1:0] bd_addr,
  output logic [7:0]                bd_data
);

  localparam int         ADDR_NIBBLES = SRAM_ADDR_WIDTH / 4;
  localparam int         DUMMY_FALLS  = 2 * DUMMY_BYTES;
  localparam logic [7:0] ADDR_LAST    = 8'(ADDR_NIBBLES - 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, DUMMY, RDATA, IGNORE} state_t;

  state_t state, state_next;

  logic [1:0] cs_sync, sck_sync;
  logic       cs_prev, sck_prev;
  logic [3:0] sio_d1, sio_d2;
  logic       sck_rise, sck_fall, cs_fall, cs_rise;

  logic [7:0]                cnt;
  logic [7:0]                cmd_shift;
  logic [7:0]                cmd_byte;
  logic                      cmd_last;
  logic                      dummy_last;
  logic                      is_write;
  logic [MEM_ADDR_WIDTH-1:0] addr;
  logic [3:0]                wr_hi;
  logic [3:0]                shift_lo;
  logic [3:0]                sio_out;
  logic [3:0]                sio_en;
  logic                      mem_we;
  logic [7:0]                mem_wdata;
  logic [7:0]                rd_byte;

  logic [7:0] mem [2**MEM_ADDR_WIDTH];

  // Two-flop synchronizers for CS/SCK, matching delay on the data lanes, and
  // a third flop on CS/SCK for edge detection; busy follows the synchronized CS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync  <= 2'b11;
      cs_prev  <= 1'b1;
      sck_sync <= 2'b00;
      sck_prev <= 1'b0;
      sio_d1   <= 4'h0;
      sio_d2   <= 4'h0;
      busy     <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[0], cs_pin};
      cs_prev  <= cs_sync[1];
      sck_sync <= {sck_sync[0], sck_pin};
      sck_prev <= sck_sync[1];
      sio_d1   <= sio_pin;
      sio_d2   <= sio_d1;
      busy     <= ~cs_sync[1];
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_prev;
  assign sck_fall = ~sck_sync[1] & sck_prev;
  assign cs_fall  = ~cs_sync[1] & cs_prev;
  assign cs_rise  = cs_sync[1] & ~cs_prev;

  assign cmd_byte   = quad_mode ? {cmd_shift[3:0], sio_d2} : {cmd_shift[6:0], sio_d2[0]};
  assign cmd_last   = quad_mode ? (cnt == 8'd1) : (cnt == 8'd7);
  assign dummy_last = (int'(cnt) + 1) >= DUMMY_FALLS;
  assign rd_byte    = mem[addr];
  assign bd_data    = mem[bd_addr];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode; a deselect always returns to IDLE, even mid-edge.
  always_comb begin
    state_next = state;
    if (cs_rise) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:  if (cs_fall) state_next = CMD;
        CMD:   if (sck_rise && cmd_last) begin
                 if (quad_mode && (cmd_byte == 8'h02 || cmd_byte == 8'h03)) state_next = ADDR;
                 else                                                        state_next = IGNORE;
               end
        ADDR:  if (sck_rise && cnt == ADDR_LAST) begin
                 if (is_write)             state_next = WDATA;
                 else if (DUMMY_BYTES > 0) state_next = DUMMY;
                 else                      state_next = RDATA;
               end
        DUMMY: if (sck_fall && dummy_last) state_next = RDATA;
        default: ;
      endcase
    end
  end

  // Memory write strobe: the second nibble of a byte completes it, unless CS is leaving.
  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = {wr_hi, sio_d2};
    if (state == WDATA && sck_rise && !cs_rise && cnt[0]) mem_we = 1'b1;
  end

  // Shift registers, counters, mode flag and lane drivers; inputs move on
  // SCK rises, outputs on SCK falls, and the drivers exist only in DUMMY/RDATA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 8'd0;
      cmd_shift <= 8'd0;
      is_write  <= 1'b0;
      quad_mode <= 1'b0;
      addr      <= '0;
      wr_hi     <= 4'h0;
      shift_lo  <= 4'h0;
      sio_out   <= 4'h0;
      sio_en    <= 4'h0;
    end else if (cs_rise) begin
      cnt    <= 8'd0;
      sio_en <= 4'h0;
    end else begin
      if (state_next != state)
        cnt <= 8'd0;
      else if ((sck_rise && (state == CMD || state == ADDR || state == WDATA)) ||
               (sck_fall && (state == DUMMY || state == RDATA)))
        cnt <= cnt + 8'd1;

      if (state != DUMMY && state != RDATA) sio_en <= 4'h0;

      case (state)
        IDLE: if (cs_fall) addr <= '0;
        CMD: if (sck_rise) begin
          cmd_shift <= cmd_byte;
          if (cmd_last) begin
            is_write <= (cmd_byte == 8'h02);
            if (!quad_mode && cmd_byte == 8'h38) quad_mode <= 1'b1;
            if (quad_mode && cmd_byte == 8'hFF)  quad_mode <= 1'b0;
          end
        end
        ADDR: if (sck_rise) addr <= {addr[MEM_ADDR_WIDTH-5:0], sio_d2};
        WDATA: if (sck_rise) begin
          if (!cnt[0]) wr_hi <= sio_d2;
          else         addr  <= addr + 1'b1;
        end
        DUMMY: if (sck_fall) begin
          sio_out <= 4'h0;
          if (quad_mode) sio_en <= 4'hF;
        end
        RDATA: if (sck_fall) begin
          if (quad_mode) sio_en <= 4'hF;
          if (!cnt[0]) begin
            shift_lo <= rd_byte[3:0];
            sio_out  <= rd_byte[7:4];
          end else begin
            sio_out <= shift_lo;
            addr    <= addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Byte array; deliberately not reset, contents are undefined until written.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr] <= mem_wdata;
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign sio_pin[i] = sio_en[i] ? sio_out[i] : 1'bz;
  end

endmodule

// File: tb/tb_spi_sram_target.sv
// tb_spi_sram_target: drives the target as a quad-SPI initiator, checks
// read-back data, backdoor memory contents, mode flag, busy and lane release.
module tb_spi_sram_target;

  localparam int MAW   = 10;
  localparam int DB    = 1;
  localparam int DEPTH = 2**MAW;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cs_pin;
  logic           sck_pin;
  wire  [3:0]     sio_pin;
  logic [3:0]     tb_sio;
  logic [3:0]     tb_oe;
  logic           quad_mode;
  logic           busy;
  logic [MAW-1:0] bd_addr;
  logic [7:0]     bd_data;

  int total = 0;
  int bad   = 0;

  logic [7:0] model [DEPTH];

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    int          n;
    logic [31:0] data;
    logic [31:0] exp;
  } tvec_t;

  tvec_t vecs [6];

  spi_sram_target #(.MEM_ADDR_WIDTH(MAW), .SRAM_ADDR_WIDTH(16), .DUMMY_BYTES(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs_pin    (cs_pin),
    .sck_pin   (sck_pin),
    .sio_pin   (sio_pin),
    .quad_mode (quad_mode),
    .busy      (busy),
    .bd_addr   (bd_addr),
    .bd_data   (bd_data)
  );

  for (genvar i = 0; i < 4; i++) begin : g_drv
    assign sio_pin[i] = tb_oe[i] ? tb_sio[i] : 1'bz;
  end

  // Free-running system clock.
  always #5 clk = ~clk;

  // Hard time limit so a stuck run still ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byteOf(input logic [31:0] v, input int i);
    return v[31-8*i -: 8];
  endfunction

  // One SCK period: data set at the start of the low phase, sampled at its end.
  task automatic clockNibble(input logic [3:0] d, output logic [3:0] q);
    tb_sio = d;
    tick(6);
    q = sio_pin;
    sck_pin = 1'b1;
    tick(6);
    sck_pin = 1'b0;
  endtask

  task automatic sendSpiByte(input logic [7:0] b);
    logic [3:0] q;
    cs_pin = 1'b0;
    tb_oe  = 4'b0001;
    tick(6);
    for (int i = 7; i >= 0; i--) clockNibble({3'b000, b[i]}, q);
    checkOutput("spi_no_drive", {28'h0, dut.sio_en}, 32'h0);
    tick(4);
    cs_pin = 1'b1;
    tb_oe  = 4'h0;
    tick(6);
  endtask

  task automatic sendQuadHeader(input logic [7:0] cmd, input logic [15:0] a);
    logic [3:0] q;
    cs_pin = 1'b0;
    tb_oe  = 4'hF;
    tick(6);
    clockNibble(cmd[7:4], q);
    clockNibble(cmd[3:0], q);
    for (int i = 3; i >= 0; i--) clockNibble(a[4*i +: 4], q);
  endtask

  // One complete quad transaction (write or read) as described by a vector.
  task automatic applyStimulus(input tvec_t v, output logic [31:0] got, output logic [7:0] dummy);
    logic [3:0] q, hi;
    logic [7:0] b;
    got   = 32'h0;
    dummy = 8'h0;
    sendQuadHeader(v.wr ? 8'h02 : 8'h03, v.addr);
    if (v.wr) begin
      for (int i = 0; i < v.n; i++) begin
        b = byteOf(v.data, i);
        clockNibble(b[7:4], q);
        clockNibble(b[3:0], q);
      end
      tb_oe = 4'h0;
      tick(5);
      checkOutput("wr_no_drive", {28'h0, dut.sio_en}, 32'h0);
      tick(1);
      cs_pin = 1'b1;
      tick(8);
    end else begin
      tb_oe = 4'h0;
      for (int i = 0; i < 2*DB; i++) begin
        clockNibble(4'h0, q);
        dummy = {dummy[3:0], q};
      end
      for (int i = 0; i < v.n; i++) begin
        clockNibble(4'h0, hi);
        clockNibble(4'h0, q);
        got[31-8*i -: 8] = {hi, q};
      end
      tick(4);
      cs_pin = 1'b1;
      tick(3);
      checkOutput("rd_release", {28'h0, dut.sio_en}, 32'h0);
      checkOutput("rd_busy_low", {31'h0, busy}, 32'h0);
      tick(5);
    end
  endtask

  task automatic checkBackdoor(input string name, input int a, input logic [7:0] exp);
    bd_addr = MAW'(a);
    #1;
    checkOutput(name, {24'h0, bd_data}, {24'h0, exp});
  endtask

  initial begin
    logic [31:0] got, expv;
    logic [7:0]  dummy, b;
    logic [3:0]  q;
    tvec_t       w, r;
    int          a;

    rst_n = 1'b0; cs_pin = 1'b1; sck_pin = 1'b0;
    tb_sio = 4'h0; tb_oe = 4'h0; bd_addr = '0;
    tick(3);
    checkOutput("rst_quad", {31'h0, quad_mode}, 32'h0);
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_lanes", {28'h0, dut.sio_en}, 32'h0);
    rst_n = 1'b1;
    tick(4);

    // EQIO in SPI mode, with busy latency check on the CS fall.
    cs_pin = 1'b0;
    tick(2);
    checkOutput("busy_early", {31'h0, busy}, 32'h0);
    tick(1);
    checkOutput("busy_rise", {31'h0, busy}, 32'h1);
    cs_pin = 1'b1;
    tick(8);
    sendSpiByte(8'h38);
    checkOutput("eqio_quad", {31'h0, quad_mode}, 32'h1);
    checkOutput("eqio_busy", {31'h0, busy}, 32'h0);

    vecs[0] = '{wr: 1'b1, addr: 16'h0010, n: 2, data: 32'hA53C_0000, exp: 32'hA53C_0000};
    vecs[1] = '{wr: 1'b0, addr: 16'h0010, n: 2, data: 32'h0,         exp: 32'hA53C_0000};
    vecs[2] = '{wr: 1'b1, addr: 16'h03FF, n: 2, data: 32'h1122_0000, exp: 32'h1122_0000};
    vecs[3] = '{wr: 1'b0, addr: 16'hFC00, n: 1, data: 32'h0,         exp: 32'h2200_0000};
    vecs[4] = '{wr: 1'b0, addr: 16'h03FF, n: 2, data: 32'h0,         exp: 32'h1122_0000};
    vecs[5] = '{wr: 1'b1, addr: 16'h0020, n: 1, data: 32'h5A00_0000, exp: 32'h5A00_0000};

    for (int k = 0; k < 6; k++) begin
      applyStimulus(vecs[k], got, dummy);
      if (vecs[k].wr) begin
        for (int i = 0; i < vecs[k].n; i++) begin
          a = (int'(vecs[k].addr) + i) % DEPTH;
          model[a] = byteOf(vecs[k].data, i);
          checkBackdoor($sformatf("vec%0d_bd%0d", k, i), a, byteOf(vecs[k].exp, i));
        end
      end else begin
        checkOutput($sformatf("vec%0d_dummy", k), {24'h0, dummy}, 32'h0);
        checkOutput($sformatf("vec%0d_data", k), got, vecs[k].exp);
      end
    end

    // Abort after one write-data nibble: the half byte must not land.
    sendQuadHeader(8'h02, 16'h0020);
    clockNibble(4'hF, q);
    tick(4);
    cs_pin = 1'b1;
    tb_oe  = 4'h0;
    tick(4);
    checkOutput("abort_busy", {31'h0, busy}, 32'h0);
    checkBackdoor("abort_mem", 32'h20, 8'h5A);
    r = '{wr: 1'b0, addr: 16'h0020, n: 1, data: 32'h0, exp: 32'h0};
    applyStimulus(r, got, dummy);
    checkOutput("abort_next_rd", got, 32'h5A00_0000);

    // Random write/read-back pairs against the array model, reads aliased high.
    for (int k = 0; k < 8; k++) begin
      w.wr   = 1'b1;
      w.addr = 16'($urandom);
      w.n    = $urandom_range(1, 4);
      w.data = $urandom;
      w.exp  = 32'h0;
      applyStimulus(w, got, dummy);
      for (int i = 0; i < w.n; i++) model[(int'(w.addr) + i) % DEPTH] = byteOf(w.data, i);
      for (int i = 0; i < w.n; i++) begin
        a = (int'(w.addr) + i) % DEPTH;
        checkBackdoor($sformatf("rnd%0d_bd%0d", k, i), a, model[a]);
      end
      r.wr   = 1'b0;
      r.addr = {6'($urandom), w.addr[MAW-1:0]};
      r.n    = w.n;
      r.data = 32'h0;
      expv   = 32'h0;
      for (int i = 0; i < r.n; i++) begin
        b = model[(int'(r.addr) + i) % DEPTH];
        expv[31-8*i -: 8] = b;
      end
      r.exp = expv;
      applyStimulus(r, got, dummy);
      checkOutput($sformatf("rnd%0d_dummy", k), {24'h0, dummy}, 32'h0);
      checkOutput($sformatf("rnd%0d_rd", k), got, r.exp);
    end

    // Leave quad mode, then a quad-style read must get no response.
    sendQuadHeader(8'hFF, 16'h0000);
    tick(4);
    cs_pin = 1'b1;
    tb_oe  = 4'h0;
    tick(8);
    checkOutput("exit_quad", {31'h0, quad_mode}, 32'h0);
    sendQuadHeader(8'h03, 16'h0010);
    tb_oe = 4'h0;
    for (int i = 0; i < 4; i++) begin
      clockNibble(4'h0, q);
      checkOutput($sformatf("spi_rd_nodrive%0d", i), {28'h0, dut.sio_en}, 32'h0);
    end
    tick(4);
    cs_pin = 1'b1;
    tick(8);
    checkOutput("spi_still", {31'h0, quad_mode}, 32'h0);

    // Re-enter quad, start a read and pull reset while the lanes are driven.
    sendSpiByte(8'h38);
    checkOutput("reenter_quad", {31'h0, quad_mode}, 32'h1);
    sendQuadHeader(8'h03, 16'h0010);
    tb_oe = 4'h0;
    for (int i = 0; i < 2*DB; i++) clockNibble(4'h0, q);
    clockNibble(4'h0, q);
    checkOutput("mid_rd_hi", {28'h0, q}, 32'hA);
    tick(4);
    checkOutput("mid_rd_driven", {28'h0, dut.sio_en}, 32'hF);
    checkOutput("mid_rd_lo", {28'h0, sio_pin}, 32'h5);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_release", {28'h0, dut.sio_en}, 32'h0);
    checkOutput("rst_clr_quad", {31'h0, quad_mode}, 32'h0);
    tick(2);
    cs_pin = 1'b1;
    rst_n  = 1'b1;
    tick(6);
    checkBackdoor("mem_kept", 32'h10, 8'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
